demux_1x2_stream: RTL

//  Routes one n-bit valid/ready stream to one of two output streams, selected per beat by in_sel.
//  It is the stream-side counterpart of an n-bit 2:1 mux: one source feeds two sinks.

---
 rtl/demux_1x2_stream_pkg.sv | 12 +
 rtl/demux_1x2_stream_if.sv | 31 +++
 rtl/demux_1x2_stream_out_reg.sv | 44 ++++
 rtl/demux_1x2_stream.sv | 109 ++++++++++
 4 files changed

// File: rtl/demux_1x2_stream_pkg.sv
// Shared constants for the 1-to-2 stream demux: port select codes and packet-lock FSM states.
package demux_1x2_stream_pkg;

  localparam logic SEL_P0 = 1'b0;
  localparam logic SEL_P1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1x2_stream_if.sv
// Bundle of the producer-side stream, the two consumer-side streams and the beat counters.
interface demux_1x2_stream_if #(
  parameter int n  = 3,
  parameter int CW = 8
);
  logic [n-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [n-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [n-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  // Demux side of the bundle
  modport slave (
    input  in_data, in_sel, in_valid, in_last, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  // Producer/consumer side of the bundle
  modport master (
    output in_data, in_sel, in_valid, in_last, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1x2_stream_out_reg.sv
// One-entry output register with valid flag; can_load says a new beat fits this cycle.
module demux_out_reg #(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] d,
  output logic [n-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         can_load
);

  logic [n-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // A load on the same cycle as a drain keeps valid high, so the port streams without bubbles
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (valid_q && q_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q        = data_q;
  assign q_valid  = valid_q;
  assign can_load = !valid_q || q_ready;

endmodule

// File: rtl/demux_1x2_stream.sv
// Routes one valid/ready stream to one of two registered outputs with per-port beat counters.
// Defining DEMUX_PKT_LOCK_EN holds the destination for a whole packet (until in_last).
module demux_1x2_stream
  import demux_1x2_stream_pkg::*;
#(
  parameter int n  = 3,
  parameter int CW = 8
) (
  input logic              clk,
  input logic              reset,
  demux_1x2_stream_if.slave bus
);

  logic          esel;
  logic          accept;
  logic          can_load0, can_load1;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

`ifdef DEMUX_PKT_LOCK_EN
  state_t state_q, state_d;
  logic   lock_sel_q, lock_sel_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= SEL_P0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // A non-last beat accepted in IDLE pins the destination until the packet's last beat
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !bus.in_last) begin
          state_d    = ST_LOCK;
          lock_sel_d = bus.in_sel;
        end
      end
      ST_LOCK: begin
        if (accept && bus.in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    esel = bus.in_sel;
    if (state_q == ST_LOCK) esel = lock_sel_q;
  end
`else
  logic unused_last;
  assign unused_last = bus.in_last;

  always_comb begin
    esel = bus.in_sel;
  end
`endif

  assign bus.in_ready = (esel == SEL_P1) ? can_load1 : can_load0;
  assign accept       = bus.in_valid && bus.in_ready;

  demux_out_reg #(.n(n)) u_out0 (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && (esel == SEL_P0)),
    .d        (bus.in_data),
    .q        (bus.out0_data),
    .q_valid  (bus.out0_valid),
    .q_ready  (bus.out0_ready),
    .can_load (can_load0)
  );

  demux_out_reg #(.n(n)) u_out1 (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && (esel == SEL_P1)),
    .d        (bus.in_data),
    .q        (bus.out1_data),
    .q_valid  (bus.out1_valid),
    .q_ready  (bus.out1_ready),
    .can_load (can_load1)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (bus.out0_valid && bus.out0_ready) cnt0_d = cnt0_q + CW'(1);
    if (bus.out1_valid && bus.out1_ready) cnt1_d = cnt1_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule
